// File: rtl/mem_io_controller.sv
// Memory/IO access controller: request/done handshake between the MAR/MDR datapath and a
// synchronous single-port RAM, plus one input port and one output port. Define MEMCTL_ADDR_CHECK_EN for illegal-address decode.
module mem_io_controller #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 9,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] IN_ADDR  = 32'h0000_0200,
    parameter logic [31:0] OUT_ADDR = 32'h0000_0201
) (
    input  logic              clk,
    input  logic              in_reset,
    input  logic              in_req,
    input  logic              in_we,
    input  logic [31:0]       in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_busy,
    output logic              out_done,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic [DATA_W-1:0] out_ram_data,
    output logic              out_ram_rden,
    output logic              out_ram_wren,
    input  logic [DATA_W-1:0] in_ram_q,
    input  logic [DATA_W-1:0] in_inport_data,
    output logic [DATA_W-1:0] out_outport
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {R_RAM, R_INPORT, R_OUTPORT, R_ILLEGAL} region_e;

`ifdef MEMCTL_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [32:0] RAM_SPAN = 33'd1 << ADDR_W;
    localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

    // Without address checking, anything that is not a port aliases into RAM.
    function automatic region_e decode(input logic [31:0] addr);
        if ({1'b0, addr} < RAM_SPAN) begin
            decode = R_RAM;
        end else if (addr == IN_ADDR) begin
            decode = R_INPORT;
        end else if (addr == OUT_ADDR) begin
            decode = R_OUTPORT;
        end else begin
            decode = ADDR_CHECK ? R_ILLEGAL : R_RAM;
        end
    endfunction

    state_e              state_q, state_d;
    region_e             region_q, region_d;
    region_e             req_region_s;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   outport_q, outport_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_rden_q, ram_rden_d;
    logic                ram_wren_q, ram_wren_d;

    assign req_region_s = decode(in_addr);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        outport_d  = outport_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_rden_d = 1'b0;
        ram_wren_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_req) begin
                    we_d     = in_we;
                    wdata_d  = in_wdata;
                    region_d = req_region_s;
                    busy_d   = 1'b1;
                    state_d  = S_ACCESS;
                    // Strobes are registered here so they appear exactly in ACCESS.
                    if (req_region_s == R_RAM) begin
                        ram_addr_d = in_addr[ADDR_W-1:0];
                        if (in_we) begin
                            ram_wren_d = 1'b1;
                            ram_data_d = in_wdata;
                        end else begin
                            ram_rden_d = 1'b1;
                        end
                    end else begin
                        ram_addr_d = ram_addr_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                err_d   = 1'b0;
                case (region_q)
                    R_RAM: begin
                        if (!we_q) begin
                            cnt_d   = CNT_LOAD;
                            state_d = S_WAIT;
                            done_d  = 1'b0;
                            err_d   = err_q;
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                    R_INPORT: begin
                        if (we_q) begin
                            err_d = ADDR_CHECK;
                        end else begin
                            rdata_d = in_inport_data;
                        end
                    end
                    R_OUTPORT: begin
                        if (we_q) begin
                            outport_d = wdata_q;
                        end else begin
                            rdata_d = outport_q;
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
            S_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rdata_d = in_ram_q;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state_q    <= S_IDLE;
            region_q   <= R_RAM;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            outport_q  <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_rden_q <= 1'b0;
            ram_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            outport_q  <= outport_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_rden_q <= ram_rden_d;
            ram_wren_q <= ram_wren_d;
        end
    end

    assign out_busy     = busy_q;
    assign out_done     = done_q;
    assign out_rdata    = rdata_q;
    assign out_err      = err_q;
    assign out_outport  = outport_q;
    assign out_ram_addr = ram_addr_q;
    assign out_ram_data = ram_data_q;
    assign out_ram_rden = ram_rden_q;
    assign out_ram_wren = ram_wren_q;

endmodule

// File: tb/tb_mem_io_controller.sv
// Directed bench for mem_io_controller: a LATENCY=3 instance with a latency-exact RAM model,
// plus a LATENCY=5 instance used for the reset-during-WAIT scenario.
module tb_mem_io_controller;

    localparam logic [31:0] IN_A  = 32'h0000_0200;
    localparam logic [31:0] OUT_A = 32'h0000_0201;
`ifdef MEMCTL_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        in_reset, in_req, in_we;
    logic [31:0] in_addr, in_wdata, in_inport_data;
    logic        busy, done, err, rden, wren;
    logic [31:0] rdata, ram_data, outport, ram_q;
    logic [8:0]  ram_addr;
    logic        busy5, done5, err5, rden5, wren5;
    logic [31:0] rdata5, ram_data5, outport5;
    logic [8:0]  ram_addr5;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_io_controller #(.DATA_W(32), .ADDR_W(9), .LATENCY(3), .IN_ADDR(IN_A), .OUT_ADDR(OUT_A)) dut (
        .clk(clk), .in_reset(in_reset), .in_req(in_req), .in_we(in_we), .in_addr(in_addr),
        .in_wdata(in_wdata), .out_busy(busy), .out_done(done), .out_rdata(rdata), .out_err(err),
        .out_ram_addr(ram_addr), .out_ram_data(ram_data), .out_ram_rden(rden), .out_ram_wren(wren),
        .in_ram_q(ram_q), .in_inport_data(in_inport_data), .out_outport(outport));

    mem_io_controller #(.DATA_W(32), .ADDR_W(9), .LATENCY(5), .IN_ADDR(IN_A), .OUT_ADDR(OUT_A)) dut5 (
        .clk(clk), .in_reset(in_reset), .in_req(in_req), .in_we(in_we), .in_addr(in_addr),
        .in_wdata(in_wdata), .out_busy(busy5), .out_done(done5), .out_rdata(rdata5), .out_err(err5),
        .out_ram_addr(ram_addr5), .out_ram_data(ram_data5), .out_ram_rden(rden5), .out_ram_wren(wren5),
        .in_ram_q(32'h5555_5555), .in_inport_data(in_inport_data), .out_outport(outport5));

    // RAM model: data valid only in cycle 1+3 after the read strobe, garbage otherwise.
    logic [31:0] mem [0:511];
    logic [31:0] pd1, pd2, pd3;
    logic        pv1, pv2, pv3;
    always @(posedge clk) begin
        if (wren) mem[ram_addr] <= ram_data;
        pd1 <= mem[ram_addr]; pv1 <= rden;
        pd2 <= pd1;           pv2 <= pv1;
        pd3 <= pd2;           pv3 <= pv2;
    end
    assign ram_q = (pv3 === 1'b1) ? pd3 : 32'hBAD0_BAD0;

    // Issue one request in cycle 0 and observe the main DUT until a few cycles after done.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [7:0] req_mask, output int done_cyc, output int done_cnt,
                              output int rden_cyc, output int wren_cyc, output logic [31:0] rd,
                              output logic er, output logic [31:0] op, output logic [8:0] saddr,
                              output logic [31:0] sdata, output logic busy1);
        done_cyc = -1; done_cnt = 0; rden_cyc = -1; wren_cyc = -1;
        rd = '0; er = 1'b0; op = '0; saddr = '0; sdata = '0; busy1 = 1'b0;
        @(negedge clk);
        in_req = 1'b1; in_we = we; in_addr = addr; in_wdata = wdata;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            in_req = (k < 8) ? req_mask[k[2:0]] : 1'b0;
            if (k == 1) busy1 = busy;
            if (rden) begin rden_cyc = k; saddr = ram_addr; end
            if (wren) begin wren_cyc = k; saddr = ram_addr; sdata = ram_data; end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = k; rd = rdata; er = err; op = outport; end
            end
            if (done_cyc > 0 && k >= done_cyc + 4) break;
        end
        in_req = 1'b0;
    endtask

    int          dc, dn, rc, wc;
    logic [31:0] rd, op, sd;
    logic        er, b1;
    logic [8:0]  sa;

    task automatic test_reset();
        in_reset = 1'b1; in_req = 1'b1; in_we = 1'b1; in_addr = OUT_A; in_wdata = 32'hFFFF_FFFF;
        in_inport_data = 32'h0;
        @(posedge clk); @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, rden, wren, err} !== 5'b0 || outport !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_hold: busy/done/rden/wren/err=%b outport=%h required 0", {busy, done, rden, wren, err}, outport);
            end
        end
        in_reset = 1'b0; in_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, rden, wren, err} !== 5'b0 || rdata !== 32'h0 || outport !== 32'h0 ||
                ram_addr !== 9'h0 || ram_data !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_idle: flags=%b rdata=%h outport=%h ram_addr=%h ram_data=%h required all 0",
                         {busy, done, rden, wren, err}, rdata, outport, ram_addr, ram_data);
            end
        end
    endtask

    task automatic test_ram_rw();
        run_access(1'b1, 32'd5, 32'hDEAD_BEEF, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (dc !== 2 || wc !== 1 || rc !== -1 || b1 !== 1'b1) begin
            miscompares++;
            $display("FAIL ram_write_timing: done=%0d wren=%0d rden=%0d busy1=%b required 2/1/-1/1", dc, wc, rc, b1);
        end
        vectors++;
        if (sa !== 9'd5 || sd !== 32'hDEAD_BEEF || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL ram_write_bus: addr=%h data=%h rdata=%h required 005/deadbeef/0", sa, sd, rd);
        end
        run_access(1'b0, 32'd5, 32'h0, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (rc !== 1 || dc !== 5 || dn !== 1 || sa !== 9'd5) begin
            miscompares++;
            $display("FAIL ram_read_timing: rden=%0d done=%0d count=%0d addr=%h required 1/5/1/005", rc, dc, dn, sa);
        end
        vectors++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL ram_read_data: rdata=%h err=%b required deadbeef/0", rd, er);
        end
        run_access(1'b1, 32'h1FF, 32'h1357_9BDF, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        run_access(1'b0, 32'h1FF, 32'h0, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (rd !== 32'h1357_9BDF || dc !== 5 || sa !== 9'h1FF) begin
            miscompares++;
            $display("FAIL ram_top_addr: rdata=%h done=%0d addr=%h required 13579bdf/5/1ff", rd, dc, sa);
        end
    endtask

    task automatic test_ports();
        run_access(1'b1, OUT_A, 32'h0000_00A5, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (dc !== 2 || op !== 32'hA5 || rd !== 32'h1357_9BDF || rc !== -1 || wc !== -1) begin
            miscompares++;
            $display("FAIL outport_write: done=%0d outport=%h rdata=%h rden=%0d wren=%0d required 2/a5/13579bdf/-1/-1", dc, op, rd, rc, wc);
        end
        run_access(1'b0, OUT_A, 32'h0, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (dc !== 2 || rd !== 32'hA5 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL outport_read: done=%0d rdata=%h err=%b required 2/a5/0", dc, rd, er);
        end
        in_inport_data = 32'h0000_1234;
        run_access(1'b0, IN_A, 32'h0, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (dc !== 2 || rd !== 32'h1234 || er !== 1'b0 || rc !== -1) begin
            miscompares++;
            $display("FAIL inport_read: done=%0d rdata=%h err=%b rden=%0d required 2/1234/0/-1", dc, rd, er, rc);
        end
        run_access(1'b1, IN_A, 32'h0000_FFFF, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (dc !== 2 || er !== CHECK_EN || rd !== 32'h1234 || op !== 32'hA5 || wc !== -1) begin
            miscompares++;
            $display("FAIL inport_write: done=%0d err=%b rdata=%h outport=%h wren=%0d required 2/%b/1234/a5/-1", dc, er, rd, op, wc, CHECK_EN);
        end
    endtask

    task automatic test_decode();
        run_access(1'b1, 32'h100, 32'hCAFE_0100, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        run_access(1'b0, 32'h300, 32'h0, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (dc !== (CHECK_EN ? 2 : 5) || er !== CHECK_EN || rc !== (CHECK_EN ? -1 : 1)) begin
            miscompares++;
            $display("FAIL decode_300_ctl: done=%0d err=%b rden=%0d required %0d/%b/%0d", dc, er, rc, CHECK_EN ? 2 : 5, CHECK_EN, CHECK_EN ? -1 : 1);
        end
        vectors++;
        if (rd !== (CHECK_EN ? 32'h1234 : 32'hCAFE_0100)) begin
            miscompares++;
            $display("FAIL decode_300_data: rdata=%h required %h", rd, CHECK_EN ? 32'h1234 : 32'hCAFE_0100);
        end
        run_access(1'b0, 32'd5, 32'h0, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL err_clear: err=%b rdata=%h required 0/deadbeef", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        // Extra requests in cycles 1, 2 and in the DONE cycle 5 must all be ignored.
        run_access(1'b0, 32'h1FF, 32'h0, 8'b0010_0110, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        vectors++;
        if (dn !== 1 || dc !== 5 || rd !== 32'h1357_9BDF) begin
            miscompares++;
            $display("FAIL busy_ignore: done_count=%0d done=%0d rdata=%h required 1/5/13579bdf", dn, dc, rd);
        end
    endtask

    task automatic test_reset_wait();
        int d5;
        @(negedge clk); in_reset = 1'b1;
        @(negedge clk); in_reset = 1'b0;
        run_access(1'b1, OUT_A, 32'h0000_0077, 8'h0, dc, dn, rc, wc, rd, er, op, sa, sd, b1);
        @(negedge clk);
        in_req = 1'b1; in_we = 1'b0; in_addr = 32'd7;
        @(negedge clk); in_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy5 !== 1'b1 || done5 !== 1'b0 || outport5 !== 32'h77) begin
            miscompares++;
            $display("FAIL wait_before_reset: busy=%b done=%b outport=%h required 1/0/77", busy5, done5, outport5);
        end
        in_reset = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        vectors++;
        if (busy5 !== 1'b0 || rden5 !== 1'b0 || done5 !== 1'b0 || outport5 !== 32'h0) begin
            miscompares++;
            $display("FAIL wait_reset: busy=%b rden=%b done=%b outport=%h required 0/0/0/0", busy5, rden5, done5, outport5);
        end
        d5 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done5 === 1'b1) d5++;
        end
        vectors++;
        if (d5 !== 0 || busy5 !== 1'b0) begin
            miscompares++;
            $display("FAIL aborted_done: done_count=%0d busy=%b required 0/0", d5, busy5);
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_ports();
        test_decode();
        test_back_to_back();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_io_controller.md
# mem_io_controller

Parametrised memory/IO access controller between the processor datapath's MAR/MDR pair and a synchronous single-port RAM. It replaces direct `rden`/`wren` strobing with a request/done handshake and a configurable RAM read latency. It decodes a 32-bit address into RAM, one memory-mapped input port, one memory-mapped output port, or an illegal region. It sits between the datapath (MAR → `in_addr`, MDR → `in_wdata`, `out_rdata` → MDR memory input) and the RAM macro.

## Interface
Parameters:
- `DATA_W`, 32, data width of RAM, ports and datapath interface
- `ADDR_W`, 9, RAM address bits; RAM occupies addresses 0 .. 2**ADDR_W-1
- `LATENCY`, 1, RAM read latency in cycles, legal range 1..7
- `IN_ADDR`, 32'h0000_0200, address of the input port; must be ≥ 2**ADDR_W
- `OUT_ADDR`, 32'h0000_0201, address of the output port; must be ≥ 2**ADDR_W and ≠ `IN_ADDR`

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge
- `in_reset` in 1: synchronous, active-high reset
- `in_req` in 1: access request, sampled only when `out_busy`=0
- `in_we` in 1: 1 = write, 0 = read; sampled with `in_req`
- `in_addr` in 32: access address; sampled with `in_req`
- `in_wdata` in DATA_W: write data; sampled with `in_req`
- `out_busy` out 1: access in progress
- `out_done` out 1: one-cycle completion pulse
- `out_rdata` out DATA_W: read result; valid with `out_done`, held until the next `out_done`
- `out_err` out 1: illegal access flag; valid with `out_done`, held until the next `out_done`
- `out_ram_addr` out ADDR_W: RAM address
- `out_ram_data` out DATA_W: RAM write data
- `out_ram_rden` out 1: RAM read strobe
- `out_ram_wren` out 1: RAM write strobe
- `in_ram_q` in DATA_W: RAM read data
- `in_inport_data` in DATA_W: external input port value
- `out_outport` out DATA_W: output port register

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: `out_busy`=0. When `in_req`=1, latch `in_we`, `in_addr` and `in_wdata`, then decode the address and go to ACCESS.
- Address decode, in priority order:
  - `addr < 2**ADDR_W` → RAM
  - `== IN_ADDR` → INPORT
  - `== OUT_ADDR` → OUTPORT
  - otherwise → ILLEGAL
- ACCESS, always one cycle:
  - RAM read: `out_ram_rden`=1 with `out_ram_addr`=`addr[ADDR_W-1:0]`. Load the wait counter with `LATENCY`-1, then go to WAIT.
  - RAM write: `out_ram_wren`=1 with address and `out_ram_data`, then go to DONE.
  - INPORT read: capture `in_inport_data` into `out_rdata`, then go to DONE.
  - OUTPORT write: load `out_outport` ← wdata, then go to DONE.
  - OUTPORT read: capture `out_outport` into `out_rdata`, then go to DONE.
  - INPORT write or ILLEGAL: set the error flag, then go to DONE. No RAM strobe and no port update.
- WAIT: hold while the counter ≠ 0, decrementing each cycle. When the counter = 0, capture `in_ram_q` into `out_rdata`, then go to DONE.
- DONE: `out_done`=1 for one cycle, `out_err` updated, then return to IDLE.
- `out_err` is 0 for every legal access.
- ILLEGAL and INPORT-write accesses leave `out_rdata` unchanged.
- RAM writes leave `out_rdata` unchanged.
- `in_req` is ignored while `out_busy`=1, including in the DONE cycle. It is not queued.
- Strobes are high only in ACCESS. `out_ram_addr` and `out_ram_data` hold their last driven values otherwise.

## Timing
- Request is sampled at the edge ending cycle 0.
- RAM read: strobe in cycle 1, `in_ram_q` captured at the end of cycle 1+`LATENCY`, `out_done` in cycle 2+`LATENCY`.
- All other accesses: `out_done` in cycle 2.
- `out_busy`=1 from cycle 1 through the DONE cycle inclusive.
- Earliest next request is sampled in the cycle after DONE, so minimum read spacing is 3+`LATENCY` cycles.
- Reset values: FSM IDLE.
  - 0: `out_busy`, `out_done`, `out_rdata`, `out_err`, `out_outport`, `out_ram_rden`, `out_ram_wren`, `out_ram_addr`, `out_ram_data`.
- Reset in any state, including mid-WAIT:
  - next cycle is IDLE and strobes are 0;
  - no `out_done` is issued for the aborted access;
  - `out_outport` is cleared.
- Reset has priority over `in_req` in the same cycle.

## Configuration
- `MEMCTL_ADDR_CHECK_EN` defined: full decode as above. INPORT-write and ILLEGAL accesses complete with `out_err`=1.
- Not defined:
  - no ILLEGAL region; any address other than `IN_ADDR` or `OUT_ADDR` aliases into RAM via `addr[ADDR_W-1:0]`;
  - INPORT writes are silently dropped;
  - `out_err` is constant 0.

## Test plan
- Reset then idle: all outputs 0 and `out_busy`=0 for 5 cycles; `in_req`=1 held high during reset produces no access.
- `LATENCY`=3: write 32'hDEAD_BEEF to address 5 (`out_done` in cycle 2), then read address 5 → `out_ram_rden` in cycle 1, `out_done` in cycle 5 with `out_rdata`=32'hDEAD_BEEF and `out_err`=0.
- Write 32'h0000_00A5 to `OUT_ADDR` → `out_outport`=32'hA5 from cycle 2. Read `OUT_ADDR` → `out_rdata`=32'hA5. Read `IN_ADDR` with `in_inport_data`=32'h1234 → `out_rdata`=32'h1234.
- With `MEMCTL_ADDR_CHECK_EN`: read 32'h0000_0300 → `out_done` in cycle 2 with `out_err`=1, `out_rdata` unchanged, no RAM strobe. Without the macro: the same address reads RAM location 9'h100 and `out_err`=0.
- `in_req` pulsed in cycles 1 and 2 during a busy read → exactly one `out_done`.
- `in_reset` asserted in WAIT of a `LATENCY`=5 read → no `out_done`; `out_busy`=0 next cycle; `out_outport` cleared to 0.
